// File: rtl/ppi_pkg.sv
// ppi_pkg: shared definitions for the PPI frame receiver.
//   - header TYPE codes
//   - frame FSM state encoding
//   - time-field offsets relative to TIME_BASE
package ppi_pkg;

  localparam logic [1:0] PPI_T_TIME = 2'b00;
  localparam logic [1:0] PPI_T_DDS  = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_CHK,
    ST_DONE
  } ppi_state_e;

  // Payload offsets from TIME_BASE; dni..s also index the committed field array.
  localparam int OFF_DNI   = 0;
  localparam int OFF_H     = 1;
  localparam int OFF_MIN   = 2;
  localparam int OFF_S     = 3;
  localparam int OFF_SETUP = 4;
  localparam int N_TFIELDS = 4;

endpackage

// File: rtl/ppi_fs_detect.sv
// ppi_fs_detect: frame-sync edge detector and chip-select decode.
// Ports:
//   clk_ppi, rst   clock / synchronous active-high reset
//   ppi_fs         raw frame-sync line
//   ppi_sel        chip-select code (0 = none, k = cs[k-1])
//   fs_pulse       registered 1-cycle pulse after ppi_fs history reads 011
//   cs             registered one-hot chip selects, coincident with fs_pulse
module ppi_fs_detect #(
  parameter int N_CS  = 3,
  parameter int SEL_W = $clog2(N_CS + 1)
) (
  input  logic             clk_ppi,
  input  logic             rst,
  input  logic             ppi_fs,
  input  logic [SEL_W-1:0] ppi_sel,
  output logic             fs_pulse,
  output logic [N_CS-1:0]  cs
);

  logic [2:0]      hist_q;
  logic            fs_pulse_q;
  logic [N_CS-1:0] cs_q;
  logic            fs_edge_d;

  // One low sample followed by two highs: a debounced rising edge. Holding
  // ppi_fs high moves the history to 111, so no repeat until it drops.
  assign fs_edge_d = (hist_q == 3'b011);

  always_ff @(posedge clk_ppi) begin
    if (rst) begin
      hist_q     <= '0;
      fs_pulse_q <= 1'b0;
      cs_q       <= '0;
    end else begin
      hist_q     <= {hist_q[1:0], ppi_fs};
      fs_pulse_q <= fs_edge_d;
      // Codes above N_CS match no k and give no pulse.
      for (int k = 0; k < N_CS; k++)
        cs_q[k] <= fs_edge_d && (int'(ppi_sel) == k + 1);
    end
  end

  assign fs_pulse = fs_pulse_q;
  assign cs       = cs_q;

endmodule

// File: rtl/ppi_frame_rx.sv
// ppi_frame_rx: parametrised PPI frame receiver.
// Parses header/payload/checksum words, writes payload to an external RAM
// port, verifies an additive checksum and commits TIME fields or fires a DDS
// update for good frames.
// Ports:
//   clk_ppi, rst                  clock / synchronous active-high reset
//   ppi_data, ppi_en, ppi_fs      PPI word, word qualifier, frame sync
//   ppi_sel                       chip-select code
//   fs_pulse, cs                  frame-sync pulse and decoded chip selects
//   bus8                          low byte of last qualified word
//   ram_we/addr/data/mode         payload write port
//   frame_done, crc_ok, crc_err   checksum result pulses
//   dds_update, time_setup        commit pulses
//   dni, h, min, s                committed time fields
//   frame_cnt, err_cnt            good-frame / error counters
module ppi_frame_rx import ppi_pkg::*; #(
  parameter  int DATA_W    = 12,
  parameter  int ADDR_W    = 8,
  parameter  int N_CS      = 3,
  parameter  int TIME_BASE = 249,
  localparam int SEL_W     = $clog2(N_CS + 1)
) (
  input  logic              clk_ppi,
  input  logic              rst,
  input  logic [DATA_W-1:0] ppi_data,
  input  logic              ppi_en,
  input  logic              ppi_fs,
  input  logic [SEL_W-1:0]  ppi_sel,
  output logic              fs_pulse,
  output logic [N_CS-1:0]   cs,
  output logic [7:0]        bus8,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_mode,
  output logic              frame_done,
  output logic              crc_ok,
  output logic              crc_err,
  output logic              dds_update,
  output logic              time_setup,
  output logic [7:0]        dni,
  output logic [7:0]        h,
  output logic [7:0]        min,
  output logic [7:0]        s,
  output logic [15:0]       frame_cnt,
  output logic [7:0]        err_cnt
);

  ppi_fs_detect #(.N_CS(N_CS), .SEL_W(SEL_W)) u_fs (
    .clk_ppi (clk_ppi),
    .rst     (rst),
    .ppi_fs  (ppi_fs),
    .ppi_sel (ppi_sel),
    .fs_pulse(fs_pulse),
    .cs      (cs)
  );

  ppi_state_e                      state_q;
  logic [ADDR_W-1:0]               len_q, idx_q, ram_addr_q;
  logic [DATA_W-1:0]               sum_q, ram_data_q;
  logic                            ram_we_q, ram_mode_q, frame_done_q, crc_ok_q, crc_err_q;
  logic                            dds_update_q, time_setup_q, setup_sh_q;
  logic [N_TFIELDS-1:0][7:0]       tsh_q, tf_q;
  logic [15:0]                     frame_cnt_q;
  logic [7:0]                      err_cnt_q, bus8_q;

  logic [7:0]        err_cnt_d;
  logic [DATA_W-1:0] sum_d;
  logic [1:0]        hdr_type_d;
  logic [ADDR_W-1:0] hdr_len_d;
  logic              sum_match_d;

  assign err_cnt_d   = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
  assign sum_d       = sum_q + ppi_data;
  assign hdr_type_d  = ppi_data[DATA_W-1 -: 2];
  assign hdr_len_d   = ppi_data[ADDR_W-1:0];
  assign sum_match_d = (ppi_data == sum_q);

  always_ff @(posedge clk_ppi) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      idx_q        <= '0;
      sum_q        <= '0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
      ram_mode_q   <= 1'b0;
      frame_done_q <= 1'b0;
      crc_ok_q     <= 1'b0;
      crc_err_q    <= 1'b0;
      dds_update_q <= 1'b0;
      time_setup_q <= 1'b0;
      setup_sh_q   <= 1'b0;
      tsh_q        <= '0;
      tf_q         <= '0;
      frame_cnt_q  <= '0;
      err_cnt_q    <= '0;
      bus8_q       <= '0;
    end else begin
      ram_we_q     <= 1'b0;
      frame_done_q <= 1'b0;
      crc_ok_q     <= 1'b0;
      crc_err_q    <= 1'b0;
      dds_update_q <= 1'b0;
      time_setup_q <= 1'b0;
      if (ppi_en) bus8_q <= ppi_data[7:0];

      unique case (state_q)
        ST_IDLE: if (fs_pulse) state_q <= ST_HDR;

        ST_HDR:
          if (fs_pulse) begin
            err_cnt_q <= err_cnt_d;
          end else if (ppi_en) begin
            if (hdr_type_d[1]) begin
              err_cnt_q <= err_cnt_d;
              state_q   <= ST_IDLE;
            end else begin
              ram_mode_q <= hdr_type_d[0];
              len_q      <= hdr_len_d;
              idx_q      <= '0;
              sum_q      <= ppi_data;
              state_q    <= (hdr_len_d == '0) ? ST_CHK : ST_DATA;
            end
          end

        ST_DATA:
          if (fs_pulse) begin
            err_cnt_q <= err_cnt_d;
            state_q   <= ST_HDR;
          end else if (ppi_en) begin
            ram_we_q   <= 1'b1;
            ram_addr_q <= idx_q;
            ram_data_q <= ppi_data;
            sum_q      <= sum_d;
            idx_q      <= idx_q + ADDR_W'(1);
            // Shadows follow every TIME frame's payload; only a good checksum
            // moves them to the outputs.
            if (!ram_mode_q) begin
              for (int f = 0; f < N_TFIELDS; f++)
                if (TIME_BASE + f < 2**ADDR_W && idx_q == ADDR_W'(TIME_BASE + f))
                  tsh_q[f] <= ppi_data[7:0];
              if (TIME_BASE + OFF_SETUP < 2**ADDR_W &&
                  idx_q == ADDR_W'(TIME_BASE + OFF_SETUP))
                setup_sh_q <= ppi_data[0];
            end
            if (idx_q == len_q - ADDR_W'(1)) state_q <= ST_CHK;
          end

        ST_CHK:
          if (fs_pulse) begin
            err_cnt_q <= err_cnt_d;
            state_q   <= ST_HDR;
          end else if (ppi_en) begin
            frame_done_q <= 1'b1;
            crc_ok_q     <= sum_match_d;
            crc_err_q    <= !sum_match_d;
            if (sum_match_d) begin
              frame_cnt_q <= frame_cnt_q + 16'd1;
              if (ram_mode_q) begin
                dds_update_q <= 1'b1;
              end else begin
                tf_q         <= tsh_q;
                time_setup_q <= setup_sh_q;
              end
            end else begin
              err_cnt_q <= err_cnt_d;
            end
            state_q <= ST_DONE;
          end

        // Commit already happened; a sync here just starts the next header.
        ST_DONE: state_q <= fs_pulse ? ST_HDR : ST_IDLE;

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus8       = bus8_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_data   = ram_data_q;
  assign ram_mode   = ram_mode_q;
  assign frame_done = frame_done_q;
  assign crc_ok     = crc_ok_q;
  assign crc_err    = crc_err_q;
  assign dds_update = dds_update_q;
  assign time_setup = time_setup_q;
  assign dni        = tf_q[OFF_DNI];
  assign h          = tf_q[OFF_H];
  assign min        = tf_q[OFF_MIN];
  assign s          = tf_q[OFF_S];
  assign frame_cnt  = frame_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_ppi_frame_rx.sv
// tb_ppi_frame_rx: randomized self-checking bench for ppi_frame_rx with a
// frame-level reference model (counters, shadow fields, committed fields).
module tb_ppi_frame_rx;
  import ppi_pkg::*;

  localparam int DW = 12, AW = 8, NCS = 3, TB_BASE = 249;

  logic          clk_ppi = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] ppi_data = '0;
  logic          ppi_en = 1'b0, ppi_fs = 1'b0;
  logic [1:0]    ppi_sel = '0;
  logic          fs_pulse, ram_we, ram_mode, frame_done, crc_ok, crc_err, dds_update, time_setup;
  logic [NCS-1:0] cs;
  logic [7:0]    bus8, dni, h, min, s, err_cnt;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic [15:0]   frame_cnt;

  always #5 clk_ppi = ~clk_ppi;

  ppi_frame_rx #(.DATA_W(DW), .ADDR_W(AW), .N_CS(NCS), .TIME_BASE(TB_BASE)) dut (
    .clk_ppi(clk_ppi), .rst(rst), .ppi_data(ppi_data), .ppi_en(ppi_en), .ppi_fs(ppi_fs),
    .ppi_sel(ppi_sel), .fs_pulse(fs_pulse), .cs(cs), .bus8(bus8), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_mode(ram_mode), .frame_done(frame_done),
    .crc_ok(crc_ok), .crc_err(crc_err), .dds_update(dds_update), .time_setup(time_setup),
    .dni(dni), .h(h), .min(min), .s(s), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [15:0]   m_frames;
  logic [7:0]    m_err;
  int            m_done;
  logic [7:0]    m_sh[5];
  logic [7:0]    m_tf[4];
  logic [DW-1:0] pl[256];

  // Observed pulse counts
  int c_fs = 0, c_done = 0;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  task automatic model_reset();
    m_frames = '0; m_err = '0;
    for (int i = 0; i < 5; i++) m_sh[i] = '0;
    for (int i = 0; i < 4; i++) m_tf[i] = '0;
  endtask

  task automatic step();
    @(posedge clk_ppi); #1;
    if (fs_pulse) c_fs++;
    if (frame_done) c_done++;
  endtask

  task automatic idle(input int n);
    ppi_en = 1'b0;
    ppi_data = DW'($urandom);
    repeat (n) step();
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    idle($urandom_range(0, 2));
    ppi_en = 1'b1; ppi_data = w;
    step();
    chk("bus8", 32'(bus8), 32'(w[7:0]));
    ppi_en = 1'b0; ppi_data = DW'($urandom);
  endtask

  task automatic check_zero();
    chk("z_fs", 32'(fs_pulse), 0);     chk("z_cs", 32'(cs), 0);
    chk("z_bus8", 32'(bus8), 0);       chk("z_we", 32'(ram_we), 0);
    chk("z_addr", 32'(ram_addr), 0);   chk("z_data", 32'(ram_data), 0);
    chk("z_mode", 32'(ram_mode), 0);   chk("z_done", 32'(frame_done), 0);
    chk("z_ok", 32'(crc_ok), 0);       chk("z_err", 32'(crc_err), 0);
    chk("z_dds", 32'(dds_update), 0);  chk("z_setup", 32'(time_setup), 0);
    chk("z_dni", 32'(dni), 0);         chk("z_h", 32'(h), 0);
    chk("z_min", 32'(min), 0);         chk("z_s", 32'(s), 0);
    chk("z_fcnt", 32'(frame_cnt), 0);  chk("z_ecnt", 32'(err_cnt), 0);
  endtask

  task automatic do_reset();
    ppi_fs = 1'b0; ppi_en = 1'b0; rst = 1'b1;
    step();
    check_zero();
    rst = 1'b0;
    model_reset();
  endtask

  // Drop then raise ppi_fs and wait (bounded) for the sync pulse.
  task automatic sync(input logic [1:0] sel);
    bit got = 0;
    ppi_sel = sel; ppi_fs = 1'b0;
    idle(1);
    ppi_fs = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      if (fs_pulse) got = 1;
    end
    chk("fs_seen", 32'(got), 1);
    if (got) chk("cs", 32'(cs), (sel == 0) ? 0 : 32'(1) << (sel - 1));
    step();
  endtask

  // cut_at >= 0: stop after payload word cut_at (abort by next sync, or reset).
  task automatic send_frame(input logic [DW-1:0] hdr, input int dl, input int cut_at,
                            input bit cut_rst, input logic [1:0] sel);
    logic [1:0]    typ;
    int            len;
    logic [DW-1:0] sum;
    bit            ok;
    typ = hdr[DW-1 -: 2];
    len = int'(hdr[AW-1:0]);
    sync(sel);
    send_word(hdr);
    if (typ[1]) begin
      m_err = sat_inc(m_err);
      idle(2);
      chk("rsv_err", 32'(err_cnt), 32'(m_err));
      chk("rsv_done", 32'(c_done), 32'(m_done));
      return;
    end
    chk("mode", 32'(ram_mode), 32'(typ[0]));
    sum = hdr;
    for (int i = 0; i < len; i++) begin
      send_word(pl[i]);
      chk("we", 32'(ram_we), 1);
      chk("waddr", 32'(ram_addr), 32'(i));
      chk("wdata", 32'(ram_data), 32'(pl[i]));
      sum += pl[i];
      if (typ == PPI_T_TIME && i >= TB_BASE && i < TB_BASE + 5) m_sh[i-TB_BASE] = pl[i][7:0];
      if (i == cut_at) begin
        if (cut_rst) begin
          ppi_fs = 1'b0; rst = 1'b1;
          step();
          check_zero();
          rst = 1'b0;
          model_reset();
        end else begin
          m_err = sat_inc(m_err);
        end
        return;
      end
    end
    ok = (dl == 0);
    send_word(sum + DW'(dl));
    m_done++;
    if (ok) begin
      m_frames++;
      if (typ == PPI_T_TIME) for (int k = 0; k < 4; k++) m_tf[k] = m_sh[k];
    end else begin
      m_err = sat_inc(m_err);
    end
    chk("done", 32'(frame_done), 1);
    chk("crc_ok", 32'(crc_ok), 32'(ok));
    chk("crc_err", 32'(crc_err), 32'(!ok));
    chk("dds", 32'(dds_update), 32'(ok && typ == PPI_T_DDS));
    chk("setup", 32'(time_setup), 32'(ok && typ == PPI_T_TIME && m_sh[4][0]));
    chk("dni", 32'(dni), 32'(m_tf[0]));   chk("h", 32'(h), 32'(m_tf[1]));
    chk("min", 32'(min), 32'(m_tf[2]));   chk("s", 32'(s), 32'(m_tf[3]));
    chk("fcnt", 32'(frame_cnt), 32'(m_frames));
    chk("ecnt", 32'(err_cnt), 32'(m_err));
    chk("done_cnt", 32'(c_done), 32'(m_done));
    idle(1);
    chk("done_1cyc", 32'(frame_done), 0);
    idle(1);
  endtask

  task automatic rand_pl();
    for (int i = 0; i < 256; i++) pl[i] = DW'($urandom);
  endtask

  initial begin
    int f0;
    logic [NCS-1:0] capcs;
    logic [1:0] typ;
    int len;
    m_done = 0;
    model_reset();
    do_reset();

    // Sync detection: one pulse, cs from ppi_sel=2, nothing more while high
    ppi_sel = 2'd2; ppi_fs = 1'b0;
    idle(3);
    f0 = c_fs; capcs = '0; ppi_fs = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (fs_pulse) capcs = cs;
    end
    chk("t1_npulse", 32'(c_fs - f0), 1);
    chk("t1_cs", 32'(capcs), 32'(3'b010));
    idle(4);
    chk("t1_nosecond", 32'(c_fs - f0), 1);
    do_reset();

    // DDS frame 0x403 with 1,2,3
    pl[0] = 12'd1; pl[1] = 12'd2; pl[2] = 12'd3;
    send_frame(12'h403, 0, -1, 0, 2'd1);
    chk("t2_fcnt", 32'(frame_cnt), 1);

    // TIME frame LEN=254, good then checksum+1
    rand_pl();
    pl[249] = 12'd5; pl[250] = 12'd13; pl[251] = 12'd45; pl[252] = 12'd30; pl[253] = 12'd1;
    send_frame(12'h0FE, 0, -1, 0, 2'd0);
    chk("t3_dni", 32'(dni), 5); chk("t3_s", 32'(s), 30);
    send_frame(12'h0FE, 1, -1, 0, 2'd3);
    chk("t4_min", 32'(min), 45); chk("t4_err", 32'(err_cnt), 1);

    // Abort by sync after payload word 10 of a 20-word frame
    rand_pl();
    send_frame({2'b01, 2'b10, 8'd20}, 0, 10, 0, 2'd0);
    rand_pl();
    send_frame({2'b00, 2'b01, 8'd7}, 0, -1, 0, 2'd2);

    // LEN=0 DDS, then reset during DATA, then a normal frame
    send_frame(12'h400, 0, -1, 0, 2'd1);
    rand_pl();
    send_frame({2'b00, 2'b00, 8'd20}, 0, 5, 1, 2'd0);
    rand_pl();
    send_frame({2'b01, 2'b00, 8'd4}, 0, -1, 0, 2'd3);
    chk("t6_fcnt", 32'(frame_cnt), 1);

    // Reserved type
    send_frame({2'b10, 2'b00, 8'd5}, 0, -1, 0, 2'd0);

    // Random frames
    for (int n = 0; n < 12; n++) begin
      rand_pl();
      typ = 2'($urandom_range(0, 1));
      len = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 12) : $urandom_range(245, 255);
      send_frame({typ, 2'($urandom), 8'(len)}, ($urandom_range(0, 3) == 0) ? 1 : 0,
                 -1, 0, 2'($urandom));
    end

    // err_cnt saturation via reserved headers
    for (int n = 0; n < 260; n++)
      send_frame({1'b1, 1'($urandom), 2'($urandom), 8'($urandom)}, 0, -1, 0, 2'd0);
    chk("sat_err", 32'(err_cnt), 255);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog timeout checks=%0d", n_chk);
    $fatal(1, "timeout");
  end

endmodule
